gate_sensor_conditioner: RTL and testbench
==========================================

// Module: gate_sensor_conditioner
// PURPOSE
//  Front end for the lion-cage gate light barriers: synchronises and debounces the two raw
//  barrier inputs (gate one = outer, gate two = inner) and drives clean levels to the lion
//  counter stage. A passage decoder classifies full crossings into single-cycle enter/exit
//  pulses and flags illegal sequences, for diagnostics and the counter's optional pulse interface.
// PARAMETERS
//  DEBOUNCE_CYCLES  16     consecutive cycles a synced input must disagree before acceptance (>=2)
//  CNT_W            8      debounce counter width; 2**CNT_W > DEBOUNCE_CYCLES
//  STUCK_CYCLES     4096   stuck-barrier timeout, used only with GATE_STUCK_DETECT_EN
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  g_one_raw    in   1  raw outer barrier, async, active high = beam broken
//  g_two_raw    in   1  raw inner barrier, async, active high = beam broken
//  g_one        out  1  debounced outer barrier level (feeds lion counter G_one)
//  g_two        out  1  debounced inner barrier level (feeds lion counter G_two)
//  enter_pulse  out  1  1-cycle pulse: completed outer->inner crossing
//  exit_pulse   out  1  1-cycle pulse: completed inner->outer crossing
//  seq_fault    out  1  1-cycle pulse: illegal sequence detected
//  stuck        out  1  level: a barrier held active >= STUCK_CYCLES (0 if feature off)
// BEHAVIOUR
//  - Reset (async assert, sync release): sync FFs, g_one, g_two, counters = 0; FSM = IDLE;
//    all pulses 0; stuck 0. Reset mid-crossing discards the crossing, no pulse.
//  - Sync: 2-FF chain per input; no logic between stages.
//  - Debounce per channel: if synced == stable: cnt<=0. Else cnt<=cnt+1; on
//    cnt==DEBOUNCE_CYCLES-1: stable<=synced, cnt<=0. Any agreeing cycle resets cnt (glitch
//    rejection). Pin-to-output latency = 2 + DEBOUNCE_CYCLES cycles.
//  - Channels independent; g_one/g_two registered directly from stable regs.
//  - Passage FSM on (A=g_one, B=g_two), evaluated each cycle, outputs registered (1 cycle
//    after the level change):
//    IDLE: A&!B->ENT1; B&!A->EXT1; A&B (both same cycle)->seq_fault, WAIT_CLR.
//    ENT1 (A): B rises->ENT2; A falls (B low)->IDLE, no pulse (balk).
//    ENT2 (A,B): A falls->ENT3; B falls->ENT1.
//    ENT3 (B): B falls->IDLE + enter_pulse; A rises->ENT2.
//    EXT1/EXT2/EXT3: mirror of ENT with A<->B; EXT3 (A) falls->IDLE + exit_pulse.
//    Any state: both inputs change in the same cycle (other than both-low->IDLE from
//    WAIT_CLR) -> seq_fault, WAIT_CLR.
//    WAIT_CLR: stay until !A&!B, then IDLE; no pulses issued.
//  - enter_pulse, exit_pulse, seq_fault mutually exclusive, never >1 cycle wide.
//  - Unused state encodings recover to WAIT_CLR.
// CONFIGURATION
//  GATE_STUCK_DETECT_EN defined: per-channel saturating timer counts while stable level=1,
//    clears when 0; stuck=1 while either timer >= STUCK_CYCLES, drops the cycle after both
//    clear. seq_fault unaffected.
//  GATE_STUCK_DETECT_EN undefined: no timers synthesised; stuck tied to 0.
// TESTING (DEBOUNCE_CYCLES=4, STUCK_CYCLES=32 for bench)
//  - Reset: rst_n=0 mid-run, async -> all outputs 0 same edge; FSM IDLE after release.
//  - Glitch: g_one_raw high 3 cycles then low -> g_one stays 0, no pulses; held 4+ cycles
//    -> g_one=1 exactly 6 cycles after the raw edge.
//  - Entry: raw A=1; B=1; A=0; B=0 (each step 10 cycles) -> exactly one enter_pulse, 1 cycle
//    after g_two falls; g_one/g_two track raw with 6-cycle latency.
//  - Exit + balk: mirror sequence -> one exit_pulse; A=1 then A=0 with B never high -> none.
//  - Fault: A,B raw rise same cycle -> one seq_fault, no enter/exit until both low, then a
//    normal entry -> enter_pulse.
//  - Stuck (macro on): A held 40 cycles -> stuck=1 from stable+32; release -> stuck=0;
//    macro off -> stuck always 0.

Source files
------------

// File: rtl/gate_sensor_conditioner.sv
// Lion-cage gate front end: 2-FF sync and debounce of both barriers, then a passage decoder.
// Optional stuck-barrier timers are built only when GATE_STUCK_DETECT_EN is defined.
module gate_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8,
    parameter int STUCK_CYCLES    = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic g_one_raw,
    input  logic g_two_raw,
    output logic g_one,
    output logic g_two,
    output logic enter_pulse,
    output logic exit_pulse,
    output logic seq_fault,
    output logic stuck
);

    typedef enum logic [2:0] {
        S_IDLE, S_ENT1, S_ENT2, S_ENT3, S_EXT1, S_EXT2, S_EXT3, S_WAIT_CLR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Index 0 = outer barrier (A), index 1 = inner barrier (B).
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            stable_q, stable_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    state_t                state_q, state_d;
    logic                  enter_q, enter_d;
    logic                  exit_q, exit_d;
    logic                  fault_q, fault_d;
    logic                  a, b;
    logic [1:0]            exp_ab, chg;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign a = stable_q[0];
    assign b = stable_q[1];

    // Each crossing state implies the levels that got us there; a change is a deviation from them.
    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            S_ENT1, S_EXT3: exp_ab = 2'b10;
            S_ENT2, S_EXT2: exp_ab = 2'b11;
            S_ENT3, S_EXT1: exp_ab = 2'b01;
            default:        exp_ab = 2'b00;
        endcase
        chg = {a, b} ^ exp_ab;

        if (state_q == S_WAIT_CLR) begin
            if (!a && !b) state_d = S_IDLE;
        end else if (chg == 2'b11) begin
            fault_d = 1'b1;
            state_d = S_WAIT_CLR;
        end else if (chg != 2'b00) begin
            case (state_q)
                S_IDLE: state_d = a ? S_ENT1 : S_EXT1;
                S_ENT1: state_d = b ? S_ENT2 : S_IDLE;
                S_ENT2: state_d = a ? S_ENT1 : S_ENT3;
                S_ENT3: begin
                    state_d = a ? S_ENT2 : S_IDLE;
                    enter_d = !a;
                end
                S_EXT1: state_d = a ? S_EXT2 : S_IDLE;
                S_EXT2: state_d = b ? S_EXT1 : S_EXT3;
                S_EXT3: begin
                    state_d = b ? S_EXT2 : S_IDLE;
                    exit_d  = !b;
                end
                default: state_d = S_WAIT_CLR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
            enter_q  <= 1'b0;
            exit_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            sync1_q  <= {g_two_raw, g_one_raw};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            enter_q  <= enter_d;
            exit_q   <= exit_d;
            fault_q  <= fault_d;
        end
    end

    assign g_one       = stable_q[0];
    assign g_two       = stable_q[1];
    assign enter_pulse = enter_q;
    assign exit_pulse  = exit_q;
    assign seq_fault   = fault_q;

`ifdef GATE_STUCK_DETECT_EN
    localparam int TW = $clog2(STUCK_CYCLES + 1);
    localparam logic [TW-1:0] T_MAX = TW'(STUCK_CYCLES);

    logic [1:0][TW-1:0] tmr_q, tmr_d;

    // Timers saturate at the threshold, so equality means "held at least STUCK_CYCLES".
    always_comb begin
        tmr_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (stable_q[i]) begin
                tmr_d[i] = (tmr_q[i] == T_MAX) ? T_MAX : tmr_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign stuck = (tmr_q[0] == T_MAX) || (tmr_q[1] == T_MAX);
`else
    // No timers in this build; the threshold is never negative, so this is constant 0.
    assign stuck = (STUCK_CYCLES < 0);
`endif

endmodule

// File: tb/tb_gate_sensor_conditioner.sv
// Bench for gate_sensor_conditioner: pulse scoreboard plus debounce-latency and stuck checks.
module tb_gate_sensor_conditioner;

    localparam int DEB = 4;
    localparam int STK = 32;
    localparam int LAT = 2 + DEB;
`ifdef GATE_STUCK_DETECT_EN
    localparam int STUCK_ON = 1;
`else
    localparam int STUCK_ON = 0;
`endif
    localparam logic [2:0] EV_NONE = 3'b000;
    localparam logic [2:0] EV_ENT  = 3'b001;
    localparam logic [2:0] EV_EXT  = 3'b010;
    localparam logic [2:0] EV_FLT  = 3'b100;

    typedef struct {
        logic [2:0] vec;
        int         cyc;
    } evt_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic g_one_raw = 1'b0;
    logic g_two_raw = 1'b0;
    logic g_one, g_two, enter_pulse, exit_pulse, seq_fault, stuck;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_a = 1'b0;
    logic exp_b = 1'b0;
    evt_t sb_q[$];

    gate_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(8),
        .STUCK_CYCLES(STK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .g_one_raw(g_one_raw),
        .g_two_raw(g_two_raw),
        .g_one(g_one),
        .g_two(g_two),
        .enter_pulse(enter_pulse),
        .exit_pulse(exit_pulse),
        .seq_fault(seq_fault),
        .stuck(stuck)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Every pulse seen must be the next scoreboard entry, of the right kind, in the right cycle.
    initial begin
        logic [2:0] vec;
        evt_t       e;
        forever begin
            @(negedge clk);
            vec = {seq_fault, exit_pulse, enter_pulse};
            if (vec != 3'b000) begin
                if (sb_q.size() == 0) begin
                    check("spurious_pulse", int'(vec), 0);
                end else begin
                    e = sb_q.pop_front();
                    check("pulse_type", int'(vec), int'(e.vec));
                    check("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Drive a new raw pair, confirm the debounced levels flip exactly LAT cycles later,
    // and queue the pulse expected one cycle after that.
    task automatic step(input logic a, input logic b, input int hold, input logic [2:0] ev);
        int t0;
        @(negedge clk);
        g_one_raw = a;
        g_two_raw = b;
        t0 = cyc;
        if (ev != EV_NONE) sb_q.push_back('{ev, t0 + LAT + 1});
        repeat (LAT - 1) @(negedge clk);
        check("g_one_before", g_one, exp_a);
        check("g_two_before", g_two, exp_b);
        @(negedge clk);
        exp_a = a;
        exp_b = b;
        check("g_one_after", g_one, exp_a);
        check("g_two_after", g_two, exp_b);
        repeat (hold - LAT) @(negedge clk);
    endtask

    task automatic entry(input int hold);
        step(1'b1, 1'b0, hold, EV_NONE);
        step(1'b1, 1'b1, hold, EV_NONE);
        step(1'b0, 1'b1, hold, EV_NONE);
        step(1'b0, 1'b0, hold, EV_ENT);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_g_one", g_one, 0);
        check("rst_g_two", g_two, 0);
        check("rst_enter", enter_pulse, 0);
        check("rst_exit", exit_pulse, 0);
        check("rst_fault", seq_fault, 0);
        check("rst_stuck", stuck, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 3-cycle glitch is rejected.
        g_one_raw = 1'b1;
        repeat (3) @(negedge clk);
        g_one_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("glitch_g_one", g_one, 0);
        end

        // Held pulse is accepted with full latency; then a balk with no pulse.
        step(1'b1, 1'b0, 10, EV_NONE);
        step(1'b0, 1'b0, 10, EV_NONE);

        entry(10);

        step(1'b0, 1'b1, 10, EV_NONE);
        step(1'b1, 1'b1, 10, EV_NONE);
        step(1'b1, 1'b0, 10, EV_NONE);
        step(1'b0, 1'b0, 10, EV_EXT);

        // Simultaneous rise faults; no pulses until both clear, then a clean entry works.
        step(1'b1, 1'b1, 10, EV_FLT);
        step(1'b1, 1'b0, 10, EV_NONE);
        step(1'b0, 1'b0, 10, EV_NONE);
        entry(10);

        // Both levels swap mid-crossing.
        step(1'b1, 1'b0, 10, EV_NONE);
        step(1'b0, 1'b1, 10, EV_FLT);
        step(1'b0, 1'b0, 10, EV_NONE);

        // Async reset in the middle of an entry discards it.
        step(1'b1, 1'b0, 10, EV_NONE);
        step(1'b1, 1'b1, 10, EV_NONE);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_g_one", g_one, 0);
        check("arst_g_two", g_two, 0);
        check("arst_pulses", int'({seq_fault, exit_pulse, enter_pulse}), 0);
        g_one_raw = 1'b0;
        g_two_raw = 1'b0;
        exp_a = 1'b0;
        exp_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_g_one", g_one, 0);
        entry(10);

        // Stuck detection on a held outer barrier.
        begin
            int t0;
            @(negedge clk);
            g_one_raw = 1'b1;
            t0 = cyc;
            for (int i = 1; i <= 45; i++) begin
                @(negedge clk);
                if (i == LAT + STK - 1) check("stuck_early", stuck, 0);
                if (i == LAT + STK) check("stuck_set", stuck, STUCK_ON);
            end
            check("stuck_g_one", g_one, 1);
            @(negedge clk);
            g_one_raw = 1'b0;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (i == LAT) check("stuck_hold", stuck, STUCK_ON);
                if (i == LAT + 1) check("stuck_clear", stuck, 0);
            end
            exp_a = 1'b0;
        end

        repeat (10) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
